// File: rtl/ysyx_25040105_ifu_fetch.sv
// Purpose: instruction fetch unit that keeps the PC, reads one word at a time from imem and hands {inst, pc, fault} to decode.
// Latency: a request is issued from S_REQ. Best case, inst_valid asserts the cycle after rsp_valid.
// Backpressure: the imem request is held stable until req_ready. inst/inst_pc/inst_fault are held until inst_ready. Responses are never stalled.
module ysyx_25040105_ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted
);

    localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_HALT
    } state_t;

    state_t         r_state;
    logic [31:0]    r_pc;
    logic           r_drop;
    logic [WDW-1:0] r_wdog;
    logic [31:0]    r_inst;
    logic [31:0]    r_inst_pc;
    logic           r_fault;

    state_t         w_state_nxt;
    logic [31:0]    w_pc_nxt;
    logic           w_drop_nxt;
    logic [WDW-1:0] w_wdog_nxt;
    logic [31:0]    w_inst_nxt;
    logic [31:0]    w_inst_pc_nxt;
    logic           w_fault_nxt;

    logic   w_misaligned;
    logic   w_req_fire;
    logic   w_timeout;
    state_t w_resume;

    // A misaligned PC never reaches the memory; it becomes a fault in S_OUT instead.
    assign w_misaligned   = (r_pc[1:0] != 2'b00);
    assign w_req_fire     = imem_req_valid & imem_req_ready;
    assign w_timeout      = (TIMEOUT != 0) && (r_wdog == WDOG_LAST);
    assign w_resume       = halt ? S_HALT : S_REQ;

    assign imem_req_valid = (r_state == S_REQ) && !w_misaligned;
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == S_OUT);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign inst_fault     = r_fault;
    assign halted         = (r_state == S_HALT);

    // Next-state and datapath update; redirect always overrides the sequential PC outside S_HALT.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_drop_nxt    = r_drop;
        w_wdog_nxt    = r_wdog;
        w_inst_nxt    = r_inst;
        w_inst_pc_nxt = r_inst_pc;
        w_fault_nxt   = r_fault;
        case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                end
                w_state_nxt = w_resume;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                    // An accepted request whose PC was just replaced must have its response thrown away.
                    if (w_req_fire) begin
                        w_state_nxt = S_WAIT;
                        w_wdog_nxt  = '0;
                        w_drop_nxt  = 1'b1;
                    end
                end else if (w_misaligned) begin
                    w_state_nxt   = S_OUT;
                    w_inst_nxt    = NOP;
                    w_fault_nxt   = 1'b1;
                    w_inst_pc_nxt = r_pc;
                end else if (w_req_fire) begin
                    w_state_nxt = S_WAIT;
                    w_wdog_nxt  = '0;
                    w_drop_nxt  = 1'b0;
                end
            end
            S_WAIT: begin
                w_wdog_nxt = r_wdog + 1'b1;
                if (redirect_valid) begin
                    w_pc_nxt = redirect_pc;
                    // If the outstanding fetch ends this very cycle there is nothing left to drop.
                    if (imem_rsp_valid || w_timeout) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = w_resume;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = w_resume;
                    end else begin
                        w_inst_nxt    = imem_rsp_err ? NOP : imem_rsp_data;
                        w_fault_nxt   = imem_rsp_err;
                        w_inst_pc_nxt = r_pc;
                        w_state_nxt   = S_OUT;
                    end
                end else if (w_timeout) begin
                    // A timed-out fetch that was already abandoned is simply refetched at the new PC.
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = w_resume;
                    end else begin
                        w_inst_nxt    = NOP;
                        w_fault_nxt   = 1'b1;
                        w_inst_pc_nxt = r_pc;
                        w_state_nxt   = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_state_nxt = w_resume;
                end else if (inst_ready) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = w_resume;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any outstanding fetch immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_drop    <= 1'b0;
            r_wdog    <= '0;
            r_inst    <= 32'h0;
            r_inst_pc <= RESET_PC;
            r_fault   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_drop    <= w_drop_nxt;
            r_wdog    <= w_wdog_nxt;
            r_inst    <= w_inst_nxt;
            r_inst_pc <= w_inst_pc_nxt;
            r_fault   <= w_fault_nxt;
        end
    end

endmodule

// File: tb/tb_ysyx_25040105_ifu_fetch.sv
// Purpose: directed, self-checking bench for the instruction fetch unit.
// Latency: inputs are driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: imem ready and decode ready are driven explicitly by each sequence.
module tb_ysyx_25040105_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[4];

    ysyx_25040105_ifu_fetch #(
        .RESET_PC (32'h8000_0000),
        .TIMEOUT  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"},  32'(imem_req_valid), 32'd0);
        chk({tag, "_req_addr"},   imem_req_addr,       32'h8000_0000);
        chk({tag, "_inst_valid"}, 32'(inst_valid),     32'd0);
        chk({tag, "_inst"},       inst,                32'h0);
        chk({tag, "_inst_pc"},    inst_pc,             32'h8000_0000);
        chk({tag, "_fault"},      32'(inst_fault),     32'd0);
        chk({tag, "_halted"},     32'(halted),         32'd0);
    endtask

    // Wait (bounded) for a request, check its address, then accept it.
    task automatic accept(input logic [31:0] exp_addr, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_req_seen"}, 32'(seen), 32'd1);
        chk({tag, "_req_addr"}, imem_req_addr, exp_addr);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    task automatic check_out(input logic [31:0] e_inst, input logic [31:0] e_pc,
                             input logic e_fault, input string tag);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_inst"},       inst,            e_inst);
        chk({tag, "_inst_pc"},    inst_pc,         e_pc);
        chk({tag, "_fault"},      32'(inst_fault), 32'(e_fault));
    endtask

    task automatic take();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h8000_0000, 32'h0010_0093, 1'b0, 32'h0010_0093, 1'b0};
        vecs[1] = '{32'h8000_0004, 32'h0020_0113, 1'b0, 32'h0020_0113, 1'b0};
        vecs[2] = '{32'h8000_0008, 32'hDEAD_BEEF, 1'b1, 32'h0000_0013, 1'b1};
        vecs[3] = '{32'h8000_000C, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};

        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;

        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Sequential fetches, including an access error turning into a NOP fault.
        for (int i = 0; i < 4; i++) begin
            accept(vecs[i].addr, $sformatf("vec%0d", i));
            respond(vecs[i].data, vecs[i].err);
            check_out(vecs[i].exp_inst, vecs[i].addr, vecs[i].exp_fault, $sformatf("vec%0d", i));
            take();
        end

        // Decode stalls for 5 cycles: output held, no new request.
        accept(32'h8000_0010, "stall");
        respond(32'h0040_0213, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_out(32'h0040_0213, 32'h8000_0010, 1'b0, $sformatf("stall%0d", i));
            chk($sformatf("stall%0d_no_req", i), 32'(imem_req_valid), 32'd0);
            tick();
        end
        take();

        // Redirect in S_WAIT: the stale response is discarded and the new PC fetched.
        accept(32'h8000_0014, "redir");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        respond(32'hDEAD_BEEF, 1'b0);
        chk("redir_stale_hidden", 32'(inst_valid), 32'd0);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
        accept(32'h8000_0100, "redir_new");
        respond(32'h0030_0193, 1'b0);
        check_out(32'h0030_0193, 32'h8000_0100, 1'b0, "redir_new");
        take();

        // Redirect a pending request to a misaligned PC: no request, NOP fault instead.
        chk("mis_pending_addr", imem_req_addr, 32'h8000_0104);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        chk("mis_no_req", 32'(imem_req_valid), 32'd0);
        chk("mis_addr", imem_req_addr, 32'h8000_0102);
        tick();
        chk("mis_no_req2", 32'(imem_req_valid), 32'd0);
        check_out(32'h0000_0013, 32'h8000_0102, 1'b1, "mis");

        // Redirect together with the decode handshake: PC takes the redirect, not +4.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        chk("redir_out_drop_valid", 32'(inst_valid), 32'd0);

        // Watchdog: TIMEOUT=4, no response, fault 4 cycles after acceptance.
        accept(32'h8000_0200, "tmo");
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        chk("tmo_not_yet", 32'(inst_valid), 32'd0);
        tick();
        check_out(32'h0000_0013, 32'h8000_0200, 1'b1, "tmo");
        respond(32'h1234_5678, 1'b0);
        check_out(32'h0000_0013, 32'h8000_0200, 1'b1, "tmo_late");
        take();

        // Halt raised in S_OUT, handshake completes, then terminal halt.
        accept(32'h8000_0204, "halt");
        respond(32'h0050_0293, 1'b0);
        check_out(32'h0050_0293, 32'h8000_0204, 1'b0, "halt");
        halt       = 1'b1;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_no_req", 32'(imem_req_valid), 32'd0);
        halt           = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("halt_hold%0d_no_req", i), 32'(imem_req_valid), 32'd0);
        end
        chk("halt_still", 32'(halted), 32'd1);
        chk("halt_pc_kept", imem_req_addr, 32'h8000_0208);

        // Reset out of halt, then reset asynchronously during an outstanding fetch.
        rst_n = 1'b0;
        #2;
        chk("halt_rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        accept(32'h8000_0000, "rst2");
        respond(32'h0010_0093, 1'b0);
        check_out(32'h0010_0093, 32'h8000_0000, 1'b0, "rst2");
        take();
        accept(32'h8000_0004, "rst3");
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        tick();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("post_rst_req_addr", imem_req_addr, 32'h8000_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
